// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor slice:
//   - DEFAULT_WIDTH : default operand/result width
//   - state_t       : controller state encoding (IDLE=0, RUN=1, DONE=2).
//                     Encoding 3 is unused and recovers to IDLE.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    BAD  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
// Request/response bundle between a sequential controller (master) and the
// bit-serial subtractor (slave).
//
// Handshake: the master raises start with a, b and b_in valid; the slave
// accepts on the first rising edge where it is idle (busy=0) and captures the
// operands on that edge. busy stays high from the cycle after acceptance
// until the result is released. done marks d/b_out/overflow as valid; the
// result is held until the master raises ack, which the slave consumes on the
// next rising edge and then returns to idle. start is ignored while busy and
// ack is ignored unless done is high; neither is queued.
//
// Signals:
//   start, a, b, b_in   master -> slave   request and operands
//   ack                 master -> slave   result consumed
//   busy, done          slave -> master   status
//   d, b_out, overflow  slave -> master   registered result
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             ack;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             b_out;
  logic             overflow;

  modport master (
    output start, a, b, b_in, ack,
    input  busy, done, d, b_out, overflow
  );

  modport slave (
    input  start, a, b, b_in, ack,
    output busy, done, d, b_out, overflow
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
// One-bit full subtractor cell: diff = x - y - bin.
// Ports:
//   x    input   minuend bit
//   y    input   subtrahend bit
//   bin  input   borrow in
//   diff output  difference bit
//   bout output  borrow out
// Purely combinational.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  // Borrow when y exceeds x, or when they match and a borrow is pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial WIDTH-bit subtractor computing d = a - b - b_in, LSB first, one
// bit per clock through a single full_subtractor cell and a registered
// borrow.
// Ports:
//   clk        input   clock, rising edge
//   rst_n      input   asynchronous active-low reset
//   bus        slave   request/result bundle (see serial_subtractor_if)
//   dbg_state  output  current controller state
// All outputs are registered; there is no combinational input-to-output path.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus,
  output state_t               dbg_state
);

  localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;

  logic             capture;
  logic             shift;
  logic             finish;

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic             bor_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_msb_q;
  logic             b_msb_q;

  logic             fs_diff;
  logic             fs_bout;

  logic [WIDTH-1:0] d_q;
  logic             b_out_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  full_subtractor u_cell (
    .x    (x_q[0]),
    .y    (y_q[0]),
    .bin  (bor_q),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  // Result fills from the MSB end so that after WIDTH shifts bit 0 sits at
  // position 0.
  assign res_next = {fs_diff, res_q[WIDTH-1:1]};

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (cnt_q == LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // A simultaneous start is dropped; a new request must be seen in IDLE.
        if (bus.ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (capture) begin
      x_q     <= bus.a;
      y_q     <= bus.b;
      res_q   <= '0;
      bor_q   <= bus.b_in;
      cnt_q   <= '0;
      // Operand MSBs are shifted out during RUN; keep them for overflow.
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
    end else if (shift) begin
      x_q   <= {1'b0, x_q[WIDTH-1:1]};
      y_q   <= {1'b0, y_q[WIDTH-1:1]};
      res_q <= res_next;
      bor_q <= fs_bout;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (finish) begin
      d_q     <= res_next;
      b_out_q <= fs_bout;
      // On the final edge fs_diff is the result MSB.
      ovf_q   <= (a_msb_q ^ b_msb_q) & (fs_diff ^ a_msb_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN) || (state_d == DONE);
      done_q <= (state_d == DONE);
    end
  end

  assign bus.d        = d_q;
  assign bus.b_out    = b_out_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W+1:0] exp_q[$];
  vec_t         tbl[7];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: wide unsigned difference for d/borrow, signed
  // integer range test for overflow.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    logic [W:0] full;
    int         sr;
    logic       ov;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    sr   = int'($signed(a)) - int'($signed(b)) - int'(bin);
    ov   = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    return {full[W], ov, full[W-1:0]};
  endfunction

  // Counts edges from the accept edge (edge 1) until done is seen.
  task automatic wait_done(input int start_edges, output int edges);
    edges = start_edges;
    while (bus.done !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (bus.done !== 1'b1) begin
      check("done_timeout", 32'(bus.done), 32'd1);
    end
  endtask

  task automatic compare_result(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_d"},        32'(bus.d),        32'(e[W-1:0]));
      check({tag, "_b_out"},    32'(bus.b_out),    32'(e[W+1]));
      check({tag, "_overflow"}, 32'(bus.overflow), 32'(e[W]));
    end
  endtask

  task automatic give_ack();
    bus.ack = 1'b1;
    @(posedge clk);
    #1;
    bus.ack = 1'b0;
  endtask

  // Issues a start from IDLE, lasting one cycle.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.b_in  = bin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [W+1:0] e, input bit chk_lat);
    int edges;
    exp_q.push_back(e);
    drive_start(a, b, bin);
    wait_done(1, edges);
    if (chk_lat) check({tag, "_latency"}, 32'(edges), 32'd9);
    compare_result(tag);
    give_ack();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int           edges;
    int           t[3];
    int           nd;
    int           cyc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    tbl[0] = '{a: 8'h5A, b: 8'h23, bin: 1'b0, d: 8'h37, bo: 1'b0, ov: 1'b0};
    tbl[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1, ov: 1'b0};
    tbl[2] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, bo: 1'b0, ov: 1'b0};
    tbl[3] = '{a: 8'h00, b: 8'hFF, bin: 1'b1, d: 8'h00, bo: 1'b1, ov: 1'b0};
    tbl[4] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1};
    tbl[5] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, d: 8'h80, bo: 1'b1, ov: 1'b1};
    tbl[6] = '{a: 8'hC8, b: 8'h64, bin: 1'b0, d: 8'h64, bo: 1'b0, ov: 1'b1};

    // Reset held with start asserted: nothing may start.
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.ack   = 1'b0;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.b_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_d", 32'(bus.d), 32'd0);
      check("rst_bout", 32'(bus.b_out), 32'd0);
      check("rst_ovf", 32'(bus.overflow), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    // Basic op with latency, held result while ack is withheld.
    exp_q.push_back({tbl[0].bo, tbl[0].ov, tbl[0].d});
    drive_start(tbl[0].a, tbl[0].b, tbl[0].bin);
    bus.a = 8'h00;  // operand changes after capture must not matter
    bus.b = 8'hFF;
    wait_done(1, edges);
    check("basic_latency", 32'(edges), 32'd9);
    compare_result("basic");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_done", 32'(bus.done), 32'd1);
      check("hold_d", 32'(bus.d), 32'h37);
    end
    give_ack();
    check("ack_idle", 32'(dbg_state), 32'(IDLE));
    check("ack_busy", 32'(bus.busy), 32'd0);
    check("ack_d_held", 32'(bus.d), 32'h37);

    // Table-driven vectors.
    for (int i = 1; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin,
             {tbl[i].bo, tbl[i].ov, tbl[i].d}, 1'b1);
    end

    // start re-pulsed mid-RUN with other operands: ignored.
    exp_q.push_back({tbl[0].bo, tbl[0].ov, tbl[0].d});
    drive_start(tbl[0].a, tbl[0].b, tbl[0].bin);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.a     = 8'hFF;
    bus.b     = 8'h00;
    bus.b_in  = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(5, edges);
    check("midrun_latency", 32'(edges), 32'd9);
    compare_result("midrun_start");

    // start and ack together in DONE: back to IDLE only.
    bus.a     = 8'h11;
    bus.b     = 8'h22;
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("startack_state", 32'(dbg_state), 32'(IDLE));
      check("startack_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
    end
    check("startack_d_held", 32'(bus.d), 32'h37);

    // start and ack held high: one operation every 10 cycles.
    bus.a     = 8'h5A;
    bus.b     = 8'h23;
    bus.b_in  = 1'b0;
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    nd  = 0;
    cyc = 0;
    while (nd < 3 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done === 1'b1) begin
        t[nd] = cyc;
        check("cont_d", 32'(bus.d), 32'h37);
        nd++;
      end
    end
    bus.start = 1'b0;
    check("cont_count", 32'(nd), 32'd3);
    if (nd == 3) begin
      check("cont_gap1", 32'(t[1] - t[0]), 32'd10);
      check("cont_gap2", 32'(t[2] - t[1]), 32'd10);
    end
    @(posedge clk);
    #1;
    bus.ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("cont_idle", 32'(dbg_state), 32'(IDLE));

    // Reset during RUN after bit 4 has been processed.
    drive_start(8'hF0, 8'h0F, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_d", 32'(bus.d), 32'd0);
    check("arst_bout", 32'(bus.b_out), 32'd0);
    check("arst_ovf", 32'(bus.overflow), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", tbl[6].a, tbl[6].b, tbl[6].bin,
           {tbl[6].bo, tbl[6].ov, tbl[6].d}, 1'b1);

    // Random sweep against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom_range(0, 255));
      rb   = W'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      run_op("rand", ra, rb, rbin, model(ra, rb, rbin), 1'b0);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
